// File: rtl/clk_track_pkg.sv
`default_nettype none
// =============================================================================
// Module   : clk_track_pkg
// Brief    : Shared types and constants for the slow-clock edge tracker.
// Revision : 1.0 - initial release
// =============================================================================
package clk_track_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } track_state_t;

    // Consecutive identical samples needed before the glitch filter accepts a level
    localparam int c_FILTER_LEN = 3;

    function automatic int match_cnt_width(input int lock_count);
        return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// =============================================================================
// Module   : sync_edge_detect
// Brief    : Two-flop synchronizer, optional glitch filter (GLITCH_FILTER_EN),
//            previous-sample flop and combinational rise/fall detection.
// Revision : 1.0 - initial release
// =============================================================================
module sync_edge_detect
    import clk_track_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall,
    output logic o_level
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= w_level;
        end
    end

`ifdef GLITCH_FILTER_EN
    // A new level is accepted only when s2 agrees with its recent history;
    // otherwise the previously accepted level held in s3 persists.
    logic [c_FILTER_LEN-2:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[c_FILTER_LEN-3:0], r_s2};
        end
    end

    assign w_level = (r_hist == {(c_FILTER_LEN-1){r_s2}}) ? r_s2 : r_s3;
`else
    assign w_level = r_s2;
`endif

    assign o_rise  = w_level & ~r_s3;
    assign o_fall  = ~w_level & r_s3;
    assign o_level = w_level;

endmodule
`default_nettype wire

// File: rtl/clock_edge_tracker.sv
`default_nettype none
// =============================================================================
// Module   : clock_edge_tracker
// Brief    : Tracks a slow asynchronous clock in the clk domain: edge enables,
//            half-period measurement, lock and loss-of-signal (GLITCH_FILTER_EN
//            enables the input glitch filter).
// Revision : 1.0 - initial release
// =============================================================================
module clock_edge_tracker
    import clk_track_pkg::*;
#(
    parameter int EXPECTED_HALF = 2,
    parameter int TOLERANCE     = 0,
    parameter int LOCK_COUNT    = 4,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int                    c_MATCH_W   = match_cnt_width(LOCK_COUNT);
    localparam logic [CNT_W-1:0]      c_TIMEOUT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      c_EXPECTED  = CNT_W'(EXPECTED_HALF);
    localparam logic [CNT_W-1:0]      c_TOLERANCE = CNT_W'(TOLERANCE);
    localparam logic [c_MATCH_W-1:0]  c_LOCK_LAST = c_MATCH_W'(LOCK_COUNT - 1);

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_level;
    logic                 w_edge;
    logic                 w_saturated;
    logic                 w_measure;
    logic                 w_lost;
    logic                 w_in_tol;
    logic [CNT_W-1:0]     w_diff;

    logic [CNT_W-1:0]     r_cnt;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_MATCH_W-1:0] w_match_nxt;
    track_state_t         r_state;
    track_state_t         w_state_nxt;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (slow_clk_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_level (w_level)
    );

    assign w_edge      = w_rise | w_fall;
    assign w_saturated = (r_cnt == c_TIMEOUT);
    // Measurement is armed in every state except UNLOCKED
    assign w_measure   = w_edge && (r_state != UNLOCKED) && !w_saturated;
    assign w_lost      = !w_edge && w_saturated && (r_state != UNLOCKED);
    assign w_diff      = (r_cnt >= c_EXPECTED) ? (r_cnt - c_EXPECTED) : (c_EXPECTED - r_cnt);
    assign w_in_tol    = (w_diff <= c_TOLERANCE);

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        if (w_lost) begin
            w_state_nxt = UNLOCKED;
            w_match_nxt = '0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_edge) begin
                        w_state_nxt = ACQUIRE;
                        w_match_nxt = '0;
                    end
                end
                ACQUIRE: begin
                    if (w_edge && w_saturated) begin
                        w_match_nxt = '0;
                    end else if (w_measure) begin
                        if (!w_in_tol) begin
                            w_match_nxt = '0;
                        end else if (r_match == c_LOCK_LAST) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = r_match + c_MATCH_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    // A stale (saturated) edge means the signal dropped out briefly
                    if ((w_edge && w_saturated) || (w_measure && !w_in_tol)) begin
                        w_state_nxt = ACQUIRE;
                        w_match_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = UNLOCKED;
                    w_match_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= UNLOCKED;
            r_match      <= '0;
            r_cnt        <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_match      <= w_match_nxt;
            if (w_edge) begin
                r_cnt <= CNT_W'(1);
            end else if (!w_saturated) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            rise_pulse   <= w_edge & w_level;
            fall_pulse   <= w_edge & ~w_level;
            period_valid <= w_measure;
            if (w_measure) begin
                half_period <= r_cnt;
            end
            locked       <= (r_state == LOCKED);
            timeout      <= w_lost;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_edge_tracker.sv
`default_nettype none
// =============================================================================
// Module   : tb_clock_edge_tracker
// Brief    : Randomised and directed self-checking bench for clock_edge_tracker
//            against an event-level reference model (GLITCH_FILTER_EN aware).
// Revision : 1.0 - initial release
// =============================================================================
module tb_clock_edge_tracker;

    localparam int c_EXPECTED = 2;
    localparam int c_LOCK     = 4;
    localparam int c_TIMEOUT  = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        slow0 = 1'b0;
    logic        slow1 = 1'b0;
    logic        rise0, fall0, pv0, locked0, to0;
    logic [15:0] half0;
    logic        rise1, fall1, pv1, locked1, to1;
    logic [15:0] half1;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state: works on slow-clock edge times, not on RTL registers
    bit lvl_q[$];
    int m_cyc   = 0;
    int m_last  = 0;
    int m_run   = 0;
    bit m_armed = 1'b0;
    bit m_lock  = 1'b0;
    bit e_rise, e_fall, e_pv, e_locked, e_to;
    int e_half  = 0;
    bit cur_lvl = 1'b0;

    always #5 clk = ~clk;

    clock_edge_tracker dut0 (
        .clk          (clk),
        .reset        (reset),
        .slow_clk_in  (slow0),
        .rise_pulse   (rise0),
        .fall_pulse   (fall0),
        .half_period  (half0),
        .period_valid (pv0),
        .locked       (locked0),
        .timeout      (to0)
    );

    clock_edge_tracker #(.TOLERANCE(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .slow_clk_in  (slow1),
        .rise_pulse   (rise1),
        .fall_pulse   (fall1),
        .half_period  (half1),
        .period_valid (pv1),
        .locked       (locked1),
        .timeout      (to1)
    );

    function automatic logic [20:0] obs_vec(input bit sel);
        if (sel) return {rise1, fall1, pv1, locked1, to1, half1};
        return {rise0, fall0, pv0, locked0, to0, half0};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {e_rise, e_fall, e_pv, e_locked, e_to, 16'(e_half)};
    endfunction

    // An input level sampled at clk edge k is seen as an edge pulse after edge k+2.
    task automatic model_step(input bit rst_now, input bit lvl, input int tol);
        bit now_l, prev_l, edge_seen;
        int d, dev;
        if (rst_now) begin
            lvl_q = {1'b0, 1'b0, 1'b0, 1'b0};
            m_armed = 1'b0; m_run = 0; m_lock = 1'b0;
            e_rise = 1'b0; e_fall = 1'b0; e_pv = 1'b0; e_locked = 1'b0; e_to = 1'b0;
            e_half = 0;
            return;
        end
        m_cyc++;
        e_locked = m_lock;
        lvl_q.push_back(lvl);
        if (lvl_q.size() > 8) void'(lvl_q.pop_front());
        now_l  = lvl_q[lvl_q.size() - 3];
        prev_l = lvl_q[lvl_q.size() - 4];
        edge_seen = (now_l != prev_l);
        e_rise = edge_seen && now_l;
        e_fall = edge_seen && !now_l;
        e_pv = 1'b0;
        e_to = 1'b0;
        d = m_cyc - m_last;
        if (edge_seen) begin
            if (!m_armed) begin
                m_armed = 1'b1;
                m_run = 0;
            end else if (d >= c_TIMEOUT) begin
                m_run = 0;
                m_lock = 1'b0;
            end else begin
                e_pv = 1'b1;
                e_half = d;
                dev = (d > c_EXPECTED) ? d - c_EXPECTED : c_EXPECTED - d;
                if (dev <= tol) begin
                    m_run++;
                    if (m_run >= c_LOCK) m_lock = 1'b1;
                end else begin
                    m_run = 0;
                    m_lock = 1'b0;
                end
            end
            m_last = m_cyc;
        end else if (m_armed && d == c_TIMEOUT) begin
            e_to = 1'b1;
            m_armed = 1'b0;
            m_run = 0;
            m_lock = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst_v, input bit sel);
        reset = rst_v;
        slow0 = sel ? 1'b0 : cur_lvl;
        slow1 = sel ? cur_lvl : 1'b0;
        @(posedge clk);
        model_step(rst_v, cur_lvl, sel ? 1 : 0);
        #1;
    endtask

    task automatic do_reset(input bit sel);
        cur_lvl = 1'b0;
        repeat (3) cycle(1'b1, sel);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            cur_lvl = (i < 6) ? ((i % 2) != 0) : 1'b0;
            cycle(i < 6, 1'b0);
            if (obs_vec(0) !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%06h exp=%06h", i, obs_vec(0), exp_vec());
            end
            n_run++;
        end
    endtask

    task automatic test_nominal();
        int pv_seen = 0;
        int pv4_i = -1;
        int lock_i = -1;
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            cur_lvl = ((i / 2) % 2) != 0;
            cycle(1'b0, 1'b0);
            if (obs_vec(0) !== exp_vec()) begin
                n_fail++;
                $display("FAIL nominal i=%0d got=%06h exp=%06h", i, obs_vec(0), exp_vec());
            end
            n_run++;
            if (pv0) begin
                pv_seen++;
                if (pv_seen == 4) pv4_i = i;
            end
            if (locked0 && lock_i < 0) lock_i = i;
        end
        n_run++;
        if (pv4_i < 0 || lock_i != pv4_i + 1) begin
            n_fail++;
            $display("FAIL nominal_lock_delay got lock_i=%0d pv4_i=%0d exp lock one cycle after pv4", lock_i, pv4_i);
        end
    endtask

    task automatic test_stretch();
        int halves[$];
        int n3 = 0;
        int drops = 0;
        bit prev_locked = 1'b0;
        for (int k = 0; k < 12; k++) halves.push_back(2);
        halves.push_back(3);
        for (int k = 0; k < 12; k++) halves.push_back(2);
        do_reset(1'b0);
        foreach (halves[h]) begin
            cur_lvl = (h % 2 == 0);
            for (int j = 0; j < halves[h]; j++) begin
                cycle(1'b0, 1'b0);
                if (obs_vec(0) !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL stretch h=%0d j=%0d got=%06h exp=%06h", h, j, obs_vec(0), exp_vec());
                end
                n_run++;
                if (pv0 && half0 == 16'd3) n3++;
                if (prev_locked && !locked0) drops++;
                prev_locked = locked0;
            end
        end
        n_run++;
        if (n3 != 1 || drops != 1 || locked0 !== 1'b1) begin
            n_fail++;
            $display("FAIL stretch_summary got n3=%0d drops=%0d locked=%0b exp 1 1 1", n3, drops, locked0);
        end
    endtask

    task automatic test_timeout();
        int halves[$];
        int t = 0;
        int to_cnt = 0;
        int to_i = -1;
        int last_edge = -1;
        int edge_before_to = -1;
        bit post_checked = 1'b0;
        for (int k = 0; k < 11; k++) halves.push_back(2);
        halves.push_back(20);
        for (int k = 0; k < 6; k++) halves.push_back(2);
        do_reset(1'b0);
        foreach (halves[h]) begin
            cur_lvl = (h % 2 == 0);
            for (int j = 0; j < halves[h]; j++) begin
                cycle(1'b0, 1'b0);
                if (obs_vec(0) !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL timeout t=%0d got=%06h exp=%06h", t, obs_vec(0), exp_vec());
                end
                n_run++;
                if (to0) begin
                    to_cnt++;
                    to_i = t;
                    edge_before_to = last_edge;
                end
                if (rise0 || fall0) begin
                    if (to_i >= 0 && !post_checked) begin
                        post_checked = 1'b1;
                        n_run++;
                        if (pv0 !== 1'b0) begin
                            n_fail++;
                            $display("FAIL timeout_first_edge got pv=%0b exp 0", pv0);
                        end
                    end
                    last_edge = t;
                end
                t++;
            end
        end
        n_run++;
        if (to_cnt != 1 || to_i - edge_before_to != c_TIMEOUT || !post_checked) begin
            n_fail++;
            $display("FAIL timeout_summary got pulses=%0d delay=%0d rearm_seen=%0b exp 1 %0d 1",
                     to_cnt, to_i - edge_before_to, post_checked, c_TIMEOUT);
        end
    endtask

    task automatic test_reset_mid();
        int pre[$] = {2, 2, 4};
        int pv_pre = 0;
        int edges = 0;
        int lock_edges = -1;
        do_reset(1'b0);
        foreach (pre[h]) begin
            cur_lvl = (h % 2 == 0);
            for (int j = 0; j < pre[h]; j++) begin
                cycle(1'b0, 1'b0);
                if (obs_vec(0) !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL reset_mid_pre h=%0d got=%06h exp=%06h", h, obs_vec(0), exp_vec());
                end
                n_run++;
                if (pv0) pv_pre++;
            end
        end
        cur_lvl = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cycle(1'b1, 1'b0);
            if (obs_vec(0) !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_mid_clear got=%06h exp=000000", obs_vec(0));
            end
            n_run++;
        end
        for (int h = 0; h < 14; h++) begin
            cur_lvl = (h % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                cycle(1'b0, 1'b0);
                if (obs_vec(0) !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL reset_mid_post h=%0d got=%06h exp=%06h", h, obs_vec(0), exp_vec());
                end
                n_run++;
                if (locked0 && lock_edges < 0) lock_edges = edges;
                if (rise0 || fall0) edges++;
            end
        end
        n_run++;
        if (pv_pre != 2 || lock_edges != 5) begin
            n_fail++;
            $display("FAIL reset_mid_summary got pv_pre=%0d edges_to_lock=%0d exp 2 5", pv_pre, lock_edges);
        end
    endtask

    task automatic test_tolerance();
        int halves[$] = {2, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 2, 2};
        int pv_seen = 0;
        int pv4_t = -1;
        int lock_t = -1;
        int t = 0;
        do_reset(1'b1);
        foreach (halves[h]) begin
            cur_lvl = (h % 2 == 0);
            for (int j = 0; j < halves[h]; j++) begin
                cycle(1'b0, 1'b1);
                if (obs_vec(1) !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL tolerance t=%0d got=%06h exp=%06h", t, obs_vec(1), exp_vec());
                end
                n_run++;
                if (pv1) begin
                    pv_seen++;
                    if (pv_seen == 4) pv4_t = t;
                end
                if (locked1 && lock_t < 0) lock_t = t;
                t++;
            end
        end
        n_run++;
        if (pv4_t < 0 || lock_t != pv4_t + 1) begin
            n_fail++;
            $display("FAIL tolerance_lock got lock_t=%0d pv4_t=%0d exp lock one cycle after pv4", lock_t, pv4_t);
        end
    endtask

    task automatic test_random();
        int h;
        do_reset(1'b0);
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                cur_lvl = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    cycle(1'b1, 1'b0);
                    if (obs_vec(0) !== exp_vec()) begin
                        n_fail++;
                        $display("FAIL random_reset n=%0d got=%06h exp=%06h", n, obs_vec(0), exp_vec());
                    end
                    n_run++;
                end
            end else begin
                h = ($urandom_range(0, 99) < 70) ? 2 : int'($urandom_range(1, 12));
                cur_lvl = ~cur_lvl;
                for (int j = 0; j < h; j++) begin
                    cycle(1'b0, 1'b0);
                    if (obs_vec(0) !== exp_vec()) begin
                        n_fail++;
                        $display("FAIL random n=%0d h=%0d j=%0d got=%06h exp=%06h",
                                 n, h, j, obs_vec(0), exp_vec());
                    end
                    n_run++;
                end
            end
        end
    endtask

`ifdef GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        int widths[2] = '{1, 2};
        do_reset(1'b0);
        repeat (4) cycle(1'b0, 1'b0);
        foreach (widths[w]) begin
            for (int i = 0; i < widths[w] + 12; i++) begin
                cur_lvl = (i < widths[w]);
                cycle(1'b0, 1'b0);
                if (rise0 !== 1'b0 || fall0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_w%0d i=%0d got rise=%0b fall=%0b exp 0 0", widths[w], i, rise0, fall0);
                end
                n_run++;
            end
        end
        cur_lvl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            if (rise0 !== (i == 4)) begin
                n_fail++;
                $display("FAIL glitch_stable i=%0d got rise=%0b exp %0b", i, rise0, (i == 4));
            end
            n_run++;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef GLITCH_FILTER_EN
        test_glitch_filter();
`else
        test_nominal();
        test_stretch();
        test_timeout();
        test_reset_mid();
        test_tolerance();
        test_random();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
